i2s_tx_controller: RTL and testbench

I2S_TX_CONTROLLER -- requirements
Module: i2s_tx_controller

---
 rtl/i2s_ctrl_pkg.sv | 46 ++++
 rtl/i2s_tx_controller_sclk_divider.sv | 47 ++++
 rtl/i2s_tx_controller.sv | 195 +++++++++++++++++++
 tb/tb_i2s_tx_controller.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_ctrl_pkg
//  Description : Shared types for the I2S transmit controller: controller
//                states, slot-width encoding and slot-width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } i2s_state_e;

  typedef enum logic [1:0] {
    WLEN_8  = 2'd0,
    WLEN_16 = 2'd1,
    WLEN_24 = 2'd2,
    WLEN_32 = 2'd3
  } i2s_wlen_e;

  localparam int unsigned c_BIT_CNT_W = 6;

  // Slot width in bits for a word-length code
  function automatic logic [c_BIT_CNT_W-1:0] wlen_bits(input i2s_wlen_e len);
    case (len)
      WLEN_8:  return 6'd8;
      WLEN_16: return 6'd16;
      WLEN_24: return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

  // Index of the last bit of a frame (2W-1) for a word-length code
  function automatic logic [c_BIT_CNT_W-1:0] frame_last(input i2s_wlen_e len);
    case (len)
      WLEN_8:  return 6'd15;
      WLEN_16: return 6'd31;
      WLEN_24: return 6'd47;
      default: return 6'd63;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_controller_sclk_divider.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_sclk_divider
//  Description : Serial clock generator. Toggles sclk every i_div+1 clk
//                cycles while enabled and flags the clk edges that drive
//                sclk high (rise) and low (fall). Disabled -> sclk held 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_sclk_divider #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_sclk,
  output logic                 o_rise,
  output logic                 o_fall
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_sclk;
  logic                 w_tick;

  assign w_tick = i_en && (r_cnt == i_div);
  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick && r_sclk;
  assign o_sclk = r_sclk;

  // Half-period counter and sclk level; idle state is sclk low, counter zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_tx_controller.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_controller
//  Description : I2S stereo transmitter with a one-pair holding buffer.
//                Frames are 2W sclk periods, left slot first, MSB-first with
//                the standard one-bit ws delay. Empty buffer at a frame
//                start sends a zero frame and pulses underrun.
//                Optional macro I2S_TX_UNDERRUN_CNT_EN adds a saturating
//                16-bit underrun_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_controller
  import i2s_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic [DIV_WIDTH-1:0]  cfg_clk_div,
  input  logic [1:0]            cfg_word_len,
  input  logic [DATA_WIDTH-1:0] sample_left,
  input  logic [DATA_WIDTH-1:0] sample_right,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  sclk,
  output logic                  ws,
  output logic                  sd,
  output logic                  busy,
  output logic                  underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  i2s_state_e              r_state;
  i2s_state_e              w_state_nxt;
  logic                    r_full;
  logic [DATA_WIDTH-1:0]   r_buf_l;
  logic [DATA_WIDTH-1:0]   r_buf_r;
  logic [DIV_WIDTH-1:0]    r_div;
  i2s_wlen_e               r_len;
  logic [c_BIT_CNT_W-1:0]  r_bit;
  logic [DATA_WIDTH-1:0]   r_sh_l;
  logic [DATA_WIDTH-1:0]   r_sh_r;
  logic                    r_sd;
  logic                    r_ws;
  logic                    r_underrun;

  logic                    w_run;
  logic                    w_fall;
  logic                    w_rise_unused;
  logic                    w_start;
  logic                    w_frame_end;
  logic                    w_load;
  logic                    w_stop_done;
  logic [c_BIT_CNT_W-1:0]  w_wbits;
  logic [c_BIT_CNT_W-1:0]  w_last;
  logic [c_BIT_CNT_W-1:0]  w_ws_hi;
  logic [c_BIT_CNT_W-1:0]  w_bit_nxt;
  logic [DATA_WIDTH-1:0]   w_load_l;
  logic [DATA_WIDTH-1:0]   w_load_r;

  // sclk only runs outside IDLE; every line change happens on a fall, so the
  // rise strobe is not needed here
  assign w_run = (r_state != IDLE);

  i2s_sclk_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_sclk_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_run),
    .i_div  (r_div),
    .o_sclk (sclk),
    .o_rise (w_rise_unused),
    .o_fall (w_fall)
  );

  // r_bit is the frame bit currently on the line; 2W-1 is the right LSB
  assign w_wbits     = wlen_bits(r_len);
  assign w_last      = frame_last(r_len);
  assign w_ws_hi     = w_wbits - 6'd1;
  assign w_bit_nxt   = (r_bit == w_last) ? 6'd0 : r_bit + 6'd1;
  assign w_start     = (r_state == IDLE) && cfg_enable && r_full;
  assign w_frame_end = w_fall && (r_bit == w_last);
  assign w_load      = w_frame_end && (r_state == RUN);
  assign w_stop_done = w_frame_end && (r_state == STOP);
  assign w_load_l    = r_full ? r_buf_l : '0;
  assign w_load_r    = r_full ? r_buf_r : '0;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; STOP always drains the current frame before IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cfg_enable && r_full) w_state_nxt = RUN;
      RUN:     if (!cfg_enable)          w_state_nxt = STOP;
      STOP:    if (w_frame_end)          w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Holding buffer: capture when empty, drain at a frame load point
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full  <= 1'b0;
      r_buf_l <= '0;
      r_buf_r <= '0;
    end else if (sample_valid && !r_full) begin
      r_full  <= 1'b1;
      r_buf_l <= sample_left;
      r_buf_r <= sample_right;
    end else if (w_load) begin
      r_full  <= 1'b0;
    end
  end

  // Link configuration is frozen for the whole run
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
      r_len <= WLEN_8;
    end else if (w_start) begin
      r_div <= cfg_clk_div;
      r_len <= i2s_wlen_e'(cfg_word_len);
    end
  end

  // Serializer: the start edge acts as the previous frame's right LSB so ws
  // drops one sclk period before the first left MSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit      <= '0;
      r_sh_l     <= '0;
      r_sh_r     <= '0;
      r_sd       <= 1'b0;
      r_ws       <= 1'b1;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_start) begin
        r_bit <= frame_last(i2s_wlen_e'(cfg_word_len));
        r_ws  <= 1'b0;
        r_sd  <= 1'b0;
      end else if (w_stop_done) begin
        r_bit <= '0;
        r_ws  <= 1'b1;
        r_sd  <= 1'b0;
      end else if (w_fall) begin
        r_bit <= w_bit_nxt;
        r_ws  <= (w_bit_nxt >= w_ws_hi) && (w_bit_nxt != w_last);
        if (w_load) begin
          r_sd       <= w_load_l[DATA_WIDTH-1];
          r_sh_l     <= w_load_l << 1;
          r_sh_r     <= w_load_r;
          r_underrun <= !r_full;
        end else if (w_bit_nxt < w_wbits) begin
          r_sd   <= r_sh_l[DATA_WIDTH-1];
          r_sh_l <= r_sh_l << 1;
        end else begin
          r_sd   <= r_sh_r[DATA_WIDTH-1];
          r_sh_r <= r_sh_r << 1;
        end
      end
    end
  end

  assign sd           = r_sd;
  assign ws           = r_ws;
  assign busy         = w_run;
  assign underrun     = r_underrun;
  assign sample_ready = !r_full;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_und_cnt;

  // Saturating count of starved frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_und_cnt <= '0;
    else if (r_underrun && (r_und_cnt != 16'hFFFF)) r_und_cnt <= r_und_cnt + 16'd1;
  end

  assign underrun_count = r_und_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tx_controller
//  Description : Self-checking bench for i2s_tx_controller: directed frame
//                vectors, hand-written corner sequences and randomized runs
//                against a cycle-level behavioural model of the I2S link.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [7:0]  cfg_clk_div = 8'd0;
  logic [1:0]  cfg_word_len = 2'd0;
  logic [31:0] sample_left = 32'd0;
  logic [31:0] sample_right = 32'd0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, sclk, ws, sd, busy, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  always #5 clk = ~clk;

  i2s_tx_controller #(.DATA_WIDTH(32), .DIV_WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_enable     (cfg_enable),
    .cfg_clk_div    (cfg_clk_div),
    .cfg_word_len   (cfg_word_len),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .sclk           (sclk),
    .ws             (ws),
    .sd             (sd),
    .busy           (busy),
    .underrun       (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  typedef struct {
    logic [7:0]  div;
    logic [1:0]  len;
    logic [31:0] l;
    logic [31:0] r;
    logic [63:0] exp_frame;
    int          exp_period;
    int          exp_half;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural link model (abstract: elapsed clk count -> sclk phase/bit)
  int          m_state;      // 0 idle, 1 run, 2 stop
  bit          m_full;
  logic [31:0] m_L, m_R, m_fL, m_fR;
  int          m_div, m_W, m_t, m_fall;
  bit          m_sclk, m_ws, m_sd, m_und;

  // observations at sclk rises
  bit q_sd[$];
  bit q_ws[$];
  int q_cyc[$];
  int cyc = 0;
  bit p_sclk = 1'b0;
  int und_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    bit cap;
    int b;
    int pre;
    cyc++;
    if (!rst) begin
      m_state = 0; m_full = 0; m_sclk = 0; m_ws = 1; m_sd = 0; m_und = 0;
    end else begin
      cap   = sample_valid && !m_full;
      pre   = m_state;
      m_und = 0;
      if (pre == 0) begin
        if (cfg_enable && m_full) begin
          m_state = 1; m_div = int'(cfg_clk_div); m_W = 8 * (int'(cfg_word_len) + 1);
          m_t = 0; m_fall = 0; m_ws = 0; m_sd = 0; m_sclk = 0;
        end
      end else begin
        m_t++;
        m_sclk = ((m_t / (m_div + 1)) % 2) == 1;
        if ((m_t % (m_div + 1)) == 0 && !m_sclk) begin
          m_fall++;
          b = (m_fall - 1) % (2 * m_W);
          if (b == 0 && pre == 2) begin
            m_state = 0; m_ws = 1; m_sd = 0;
          end else begin
            if (b == 0) begin
              if (m_full) begin m_fL = m_L; m_fR = m_R; m_full = 0; end
              else begin m_fL = 0; m_fR = 0; m_und = 1; end
            end
            m_ws = (b >= m_W - 1) && (b <= 2 * m_W - 2);
            m_sd = (b < m_W) ? m_fL[31 - b] : m_fR[31 - (b - m_W)];
          end
        end
        if (pre == 1 && !cfg_enable) m_state = 2;
      end
      if (cap) begin m_full = 1; m_L = sample_left; m_R = sample_right; end
    end
    check("cycle{sclk,ws,sd,busy,ready,underrun}",
          64'({sclk, ws, sd, busy, sample_ready, underrun}),
          64'({m_sclk, m_ws, m_sd, (m_state != 0), !m_full, m_und}));
    if (!p_sclk && sclk) begin
      q_sd.push_back(sd); q_ws.push_back(ws); q_cyc.push_back(cyc);
    end
    if (underrun) und_pulses++;
    p_sclk = sclk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step();
  endtask

  task automatic apply_reset();
    cfg_enable = 0; sample_valid = 0;
    rst = 0; tick(); tick();
    rst = 1; tick();
  endtask

  task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
    int g;
    sample_left = l; sample_right = r; sample_valid = 1;
    g = 0;
    while (!sample_ready && g < 2000) begin tick(); g++; end
    check("send_pair_ready_timeout", 64'(sample_ready), 64'd1);
    tick();
    sample_valid = 0;
  endtask

  task automatic wait_rises(input int target);
    int g;
    g = 0;
    while (q_sd.size() < target && g < 3000) begin tick(); g++; end
    check("rise_wait_timeout", 64'(q_sd.size() >= target), 64'd1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 3000) begin tick(); g++; end
    check("idle_wait_timeout", 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] frame_bits(input int start, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++)
      if (start + k < q_sd.size()) r[63 - k] = q_sd[start + k];
    return r;
  endfunction

  task automatic run_vector(input vec_t v);
    int base, idx, zeros, ones;
    apply_reset();
    cfg_clk_div = v.div; cfg_word_len = v.len;
    send_pair(v.l, v.r);
    base = q_sd.size();
    cfg_enable = 1;
    wait_rises(base + 7);          // bit 5 of left slot is on the line
    cfg_enable = 0;
    wait_idle();
    check("vec_rise_count", 64'(q_sd.size() - base), 64'(1 + 2 * v.exp_half));
    check("vec_frame_bits", frame_bits(base + 1, 2 * v.exp_half), v.exp_frame);
    idx = base; zeros = 0; ones = 0;
    while (idx < q_ws.size() && q_ws[idx] == 1'b0) begin zeros++; idx++; end
    while (idx < q_ws.size() && q_ws[idx] == 1'b1) begin ones++; idx++; end
    check("vec_ws_low_run", 64'(zeros), 64'(v.exp_half));
    check("vec_ws_high_run", 64'(ones), 64'(v.exp_half));
    check("vec_sclk_period",
          64'((q_cyc.size() > base + 1) ? q_cyc[base + 1] - q_cyc[base] : -1),
          64'(v.exp_period));
    check("vec_idle_{sclk,ws,sd,busy}", 64'({sclk, ws, sd, busy}), 64'(4'b0100));
  endtask

  vec_t tv[4];

  initial begin
    int base, und0, ncyc;
    logic [31:0] l2, r2;

    tv[0] = '{8'd1, 2'd1, 32'hA5F0_1234, 32'h0F0F_ABCD, 64'hA5F0_0F0F_0000_0000, 4, 16};
    tv[1] = '{8'd0, 2'd0, 32'hC35A_7E11, 32'h96FF_00FF, 64'hC396_0000_0000_0000, 2, 8};
    tv[2] = '{8'd2, 2'd2, 32'h1234_56AB, 32'hFEDC_BA98, 64'h1234_56FE_DCBA_0000, 6, 24};
    tv[3] = '{8'd3, 2'd3, 32'h8000_0001, 32'hDEAD_BEEF, 64'h8000_0001_DEAD_BEEF, 8, 32};

    #2 rst = 0;
    tick(); tick();
    check("reset_{sclk,ws,sd,busy,underrun,ready}",
          64'({sclk, ws, sd, busy, underrun, sample_ready}), 64'(6'b010001));
    rst = 1; tick();

    for (int v = 0; v < 4; v++) run_vector(tv[v]);

    // continuous supply: three frames, never starved
    apply_reset();
    cfg_clk_div = 8'd0; cfg_word_len = 2'd0;
    sample_valid = 1; sample_left = $urandom; sample_right = $urandom;
    tick();
    base = q_sd.size(); und0 = und_pulses;
    cfg_enable = 1;
    ncyc = 0;
    while (q_sd.size() < base + 1 + 48 && ncyc < 3000) begin
      tick(); ncyc++;
      sample_left = $urandom; sample_right = $urandom;
    end
    check("cont_three_frames_reached", 64'(q_sd.size() >= base + 49), 64'd1);
    cfg_enable = 0;
    wait_idle();
    sample_valid = 0;
    check("cont_underrun_pulses", 64'(und_pulses - und0), 64'd0);

    // single pair then starvation
    apply_reset();
    cfg_clk_div = 8'd1; cfg_word_len = 2'd1;
    l2 = $urandom; r2 = $urandom;
    send_pair(l2, r2);
    base = q_sd.size(); und0 = und_pulses;
    cfg_enable = 1;
    wait_rises(base + 1 + 32 + 6);
    cfg_enable = 0;
    wait_idle();
    check("starve_frame1", frame_bits(base + 1, 32), {l2[31:16], r2[31:16], 32'd0});
    check("starve_frame2_zero", frame_bits(base + 33, 32), 64'd0);
    check("starve_underrun_pulses", 64'(und_pulses - und0), 64'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("starve_underrun_count", 64'(underrun_count), 64'd1);
`endif

    // reset in the middle of the right slot, then a fresh start
    apply_reset();
    cfg_clk_div = 8'd1; cfg_word_len = 2'd1;
    send_pair(32'h1357_0000, 32'h2468_0000);
    base = q_sd.size();
    cfg_enable = 1;
    wait_rises(base + 1 + 16 + 11);
    rst = 0;
    #1;
    check("midreset_{sclk,ws,sd,busy,underrun,ready}",
          64'({sclk, ws, sd, busy, underrun, sample_ready}), 64'(6'b010001));
    cfg_enable = 0;
    tick(); tick();
    rst = 1; tick();
    l2 = $urandom; r2 = $urandom;
    send_pair(l2, r2);
    base = q_sd.size();
    cfg_enable = 1;
    wait_rises(base + 7);
    cfg_enable = 0;
    wait_idle();
    check("midreset_fresh_frame", frame_bits(base + 1, 32), {l2[31:16], r2[31:16], 32'd0});
    check("midreset_fresh_rises", 64'(q_sd.size() - base), 64'd33);

    // randomized runs; cfg inputs keep moving to show they are held
    for (int run = 0; run < 6; run++) begin
      apply_reset();
      ncyc = int'($urandom_range(60, 900));
      for (int c = 0; c < ncyc; c++) begin
        cfg_clk_div  = 8'($urandom_range(0, 3));
        cfg_word_len = 2'($urandom_range(0, 3));
        sample_valid = ($urandom_range(0, 3) != 0);
        sample_left  = $urandom;
        sample_right = $urandom;
        cfg_enable   = (c > 3);
        tick();
      end
      cfg_enable = 0;
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
